// File: rtl/best_move_scan_ctrl.sv
// best_move_scan_ctrl
// Sequential best-square finder. It reads one score per cycle from a shared score store
// (fixed 1-cycle read latency) over squares 0..N_SQ-1 and keeps a running maximum and its
// position. The result matches a combinational max tree in which the higher index wins ties.
//
// Optional build macro: MOVE_SCAN_EARLY_EXIT_EN
//   When defined, capturing an all-ones valid score ends the scan at once. The outstanding read
//   is discarded, so the lowest index among maximal squares is reported.
//   When undefined, every scan covers all N_SQ squares.
//
// Handshake: o_rd_en/o_rd_addr issue a read in cycle c. i_score_data/i_score_valid answer it in
// cycle c+1. i_score_valid=0 marks an illegal square, which is skipped. o_done pulses for one
// cycle when o_found/o_best_score/o_best_pos take their new value. These outputs hold that value
// until the next o_done or reset.
module best_move_scan_ctrl #(
  parameter int N_SQ    = 64,
  parameter int SCORE_W = 6,
  parameter int POS_W   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_rd_en,
  output logic [POS_W-1:0]   o_rd_addr,
  input  logic [SCORE_W-1:0] i_score_data,
  input  logic               i_score_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_found,
  output logic [SCORE_W-1:0] o_best_score,
  output logic [POS_W-1:0]   o_best_pos,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [POS_W-1:0] LAST_ADDR = POS_W'(N_SQ - 1);

  state_t             r_state;
  logic               r_rd_en;
  logic [POS_W-1:0]   r_rd_addr;
  logic               r_cap_en;    // a read was issued last cycle, so data is arriving now
  logic [POS_W-1:0]   r_cap_addr;  // square whose data is arriving now
  logic               r_busy;
  logic               r_done;
  logic               r_found;
  logic [SCORE_W-1:0] r_best_score;
  logic [POS_W-1:0]   r_best_pos;
  logic               r_wfound;
  logic [SCORE_W-1:0] r_wmax;
  logic [POS_W-1:0]   r_wpos;

  logic               w_cap;
  logic               w_take;
  logic               w_nfound;
  logic [SCORE_W-1:0] w_nmax;
  logic [POS_W-1:0]   w_npos;
`ifdef MOVE_SCAN_EARLY_EXIT_EN
  logic               w_hit;
`endif

  // Capture arriving score data only while a scan owns the read port. Ties go to the later square.
  always_comb begin
    w_cap    = 1'b0;
    w_take   = 1'b0;
    w_nfound = r_wfound;
    w_nmax   = r_wmax;
    w_npos   = r_wpos;
    if ((r_state == S_SCAN || r_state == S_DRAIN) && r_cap_en && i_score_valid) begin
      w_cap = 1'b1;
    end
    if (w_cap && (!r_wfound || i_score_data >= r_wmax)) begin
      w_take = 1'b1;
    end
    if (w_cap) begin
      w_nfound = 1'b1;
    end
    if (w_take) begin
      w_nmax = i_score_data;
      w_npos = r_cap_addr;
    end
  end

`ifdef MOVE_SCAN_EARLY_EXIT_EN
  // An all-ones score cannot be beaten, so the scan may stop on it.
  assign w_hit = w_take && (i_score_data == {SCORE_W{1'b1}});
`endif

  // Scan sequencer with registered read, status and result outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_cap_en     <= 1'b0;
      r_cap_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_best_score <= '0;
      r_best_pos   <= '0;
      r_wfound     <= 1'b0;
      r_wmax       <= '0;
      r_wpos       <= '0;
    end else begin
      r_cap_en   <= r_rd_en;
      r_cap_addr <= r_rd_addr;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
          r_busy    <= 1'b0;
          if (i_start) begin
            r_state   <= S_SCAN;
            r_rd_en   <= 1'b1;
            r_busy    <= 1'b1;
            r_wfound  <= 1'b0;
            r_wmax    <= '0;
            r_wpos    <= '0;
          end
        end
        S_SCAN: begin
          if (i_abort) begin
            r_state   <= S_IDLE;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_wfound <= w_nfound;
            r_wmax   <= w_nmax;
            r_wpos   <= w_npos;
`ifdef MOVE_SCAN_EARLY_EXIT_EN
            if (w_hit) begin
              r_state      <= S_DONE;
              r_rd_en      <= 1'b0;
              r_rd_addr    <= '0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_found      <= 1'b1;
              r_best_score <= w_nmax;
              r_best_pos   <= w_npos;
            end else begin
              if (r_rd_addr == LAST_ADDR) begin
                r_state   <= S_DRAIN;
                r_rd_en   <= 1'b0;
                r_rd_addr <= '0;
              end else begin
                r_rd_addr <= r_rd_addr + POS_W'(1);
              end
            end
`else
            if (r_rd_addr == LAST_ADDR) begin
              r_state   <= S_DRAIN;
              r_rd_en   <= 1'b0;
              r_rd_addr <= '0;
            end else begin
              r_rd_addr <= r_rd_addr + POS_W'(1);
            end
`endif
          end
        end
        S_DRAIN: begin
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
          r_busy    <= 1'b0;
          if (i_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_wfound     <= w_nfound;
            r_wmax       <= w_nmax;
            r_wpos       <= w_npos;
            r_found      <= w_nfound;
            r_best_score <= w_nfound ? w_nmax : '0;
            r_best_pos   <= w_nfound ? w_npos : '0;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_en      = r_rd_en;
  assign o_rd_addr    = r_rd_addr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_found      = r_found;
  assign o_best_score = r_best_score;
  assign o_best_pos   = r_best_pos;
  assign o_state      = r_state;

endmodule

// File: tb/tb_best_move_scan_ctrl.sv
// Testbench for best_move_scan_ctrl: score-store responder, scan driver tasks, and a result
// scoreboard of {found, best_score, best_pos, latency}.
module tb_best_move_scan_ctrl;

  localparam int N_SQ    = 64;
  localparam int SCORE_W = 6;
  localparam int POS_W   = 6;
  localparam int EXP_W   = 1 + SCORE_W + POS_W + 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic               rd_en;
  logic [POS_W-1:0]   rd_addr;
  logic [SCORE_W-1:0] score_data;
  logic               score_valid;
  logic               busy;
  logic               done;
  logic               found;
  logic [SCORE_W-1:0] best_score;
  logic [POS_W-1:0]   best_pos;
  logic [1:0]         dbg_state;

  logic [SCORE_W-1:0] mem_s [N_SQ];
  logic               mem_v [N_SQ];
  logic [EXP_W-1:0]   exp_q [$];

  int n_total;
  int n_bad;
  logic               last_found;
  logic [SCORE_W-1:0] last_score;
  logic [POS_W-1:0]   last_pos;

  best_move_scan_ctrl #(.N_SQ(N_SQ), .SCORE_W(SCORE_W), .POS_W(POS_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_score_data (score_data),
    .i_score_valid(score_valid),
    .o_busy       (busy),
    .o_done       (done),
    .o_found      (found),
    .o_best_score (best_score),
    .o_best_pos   (best_pos),
    .o_state      (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Score store: 1-cycle latency. Without a read it returns a valid all-ones score,
  // which the controller must never capture.
  always @(posedge clk) begin
    if (rd_en) begin
      score_data  <= mem_s[rd_addr];
      score_valid <= mem_v[rd_addr];
    end else begin
      score_data  <= '1;
      score_valid <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: linear scan, later square wins ties; optional stop on all-ones.
  task automatic push_expected();
    logic               f;
    logic [SCORE_W-1:0] m;
    logic [POS_W-1:0]   p;
    int                 lat;
    bit                 stop;
    f = 1'b0; m = '0; p = '0; lat = N_SQ + 1; stop = 0;
    for (int i = 0; i < N_SQ; i++) begin
      if (!stop && mem_v[i] && (!f || mem_s[i] >= m)) begin
        f = 1'b1;
        m = mem_s[i];
        p = POS_W'(i);
`ifdef MOVE_SCAN_EARLY_EXIT_EN
        if (mem_s[i] == {SCORE_W{1'b1}}) begin
          lat  = i + 2;
          stop = 1;
        end
`endif
      end
    end
    exp_q.push_back({f, m, p, 8'(lat)});
  endtask

  task automatic check_done(input string tag, input int lat_obs);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_done"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_found"}, 32'(found), 32'(e[EXP_W-1]));
      chk({tag, "_score"}, 32'(best_score), 32'(e[EXP_W-2 -: SCORE_W]));
      chk({tag, "_pos"}, 32'(best_pos), 32'(e[8+POS_W-1 -: POS_W]));
      chk({tag, "_latency"}, 32'(lat_obs), 32'(e[7:0]));
      last_found = e[EXP_W-1];
      last_score = e[EXP_W-2 -: SCORE_W];
      last_pos   = e[8+POS_W-1 -: POS_W];
    end
  endtask

  // Drive start for one edge (E0); return at #1 after E0.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_scan(input string tag);
    bit got;
    push_expected();
    pulse_start();
    got = 0;
    for (int n = 1; n <= 200 && !got; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1;
        check_done(tag, n);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 0);
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_found"}, 32'(found), 0);
    chk({tag, "_score"}, 32'(best_score), 0);
    chk({tag, "_pos"}, 32'(best_pos), 0);
  endtask

  task automatic wait_addr(input string tag, input int addr);
    bit hit;
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      if (rd_addr == POS_W'(addr) && rd_en) hit = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk({tag, "_reach_addr"}, 32'(hit), 1);
  endtask

  initial begin
    int cnt;
    n_total = 0; n_bad = 0;
    start = 1'b0; abort = 1'b0; rst_n = 1'b0;
    last_found = 1'b0; last_score = '0; last_pos = '0;
    for (int i = 0; i < N_SQ; i++) begin
      mem_s[i] = '0;
      mem_v[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: i%8 everywhere
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'(i % 8); mem_v[i] = 1'b1; end
    run_scan("mod8");

    // 2: single peak
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'd3; mem_v[i] = 1'b1; end
    mem_s[17] = 6'd50;
    run_scan("peak17");

    // 3: peak on an illegal square
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'd5; mem_v[i] = 1'b1; end
    mem_s[17] = 6'd60; mem_v[17] = 1'b0;
    run_scan("invalid17");

    // 4: nothing valid
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'(i); mem_v[i] = 1'b0; end
    run_scan("none_valid");

    // random boards with frequent ties and holes
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < N_SQ; i++) begin
        mem_s[i] = 6'($urandom_range(0, 40));
        mem_v[i] = ($urandom_range(0, 3) != 0);
      end
      run_scan("random");
    end

    // 5a: start held for 80 cycles -> one done at 65, second scan sampled at edge 67
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'(i % 8); mem_v[i] = 1'b1; end
    push_expected();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk);
      #1;
      if (n == 80) start = 1'b0;
      if (done) begin
        if (cnt == 0) chk("hold_edge1", 32'(n), 65);
        else chk("hold_edge2", 32'(n), 132);
        check_done("hold", (cnt == 0) ? n : n - 67);
        cnt++;
      end
    end
    start = 1'b0;
    chk("hold_done_count", 32'(cnt), 2);
    chk("hold_queue_empty", 32'(exp_q.size()), 0);

    // 5b: abort mid-scan keeps the old results
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'($urandom_range(0, 62)); mem_v[i] = 1'b1; end
    pulse_start();
    wait_addr("abort", 30);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_busy", 32'(busy), 0);
    cnt = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 0);
    chk("abort_keep_found", 32'(found), 32'(last_found));
    chk("abort_keep_score", 32'(best_score), 32'(last_score));
    chk("abort_keep_pos", 32'(best_pos), 32'(last_pos));

    // 5c: reset mid-scan clears everything
    pulse_start();
    wait_addr("midreset", 40);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // 6: two maximal squares
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'($urandom_range(0, 62)); mem_v[i] = 1'b1; end
    mem_s[10] = 6'd63;
    mem_s[20] = 6'd63;
    run_scan("two_max");

    // back-to-back scan after the early/late finish
    for (int i = 0; i < N_SQ; i++) begin mem_s[i] = 6'($urandom_range(0, 20)); mem_v[i] = ($urandom_range(0, 1) != 0); end
    run_scan("after");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
